// File: rtl/input_framer.sv
// Purpose: captures one string and one pattern from the char stream and pre-classifies pattern metachars into a matcher job.
// Latency: job_valid rises on the edge that samples the first idle cycle after the last pattern char.
// Backpressure: job held stable in ISSUE until job_ready; chars arriving meanwhile are dropped and flagged in err[2].
module input_framer #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int DATA_W  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_W-1:0]                chardata,
    input  logic                             isstring,
    input  logic                             ispattern,
    output logic                             job_valid,
    input  logic                             job_ready,
    output logic [STR_MAX*DATA_W-1:0]        str_data,
    output logic [$clog2(STR_MAX+1)-1:0]     str_len,
    output logic [PAT_MAX*DATA_W-1:0]        pat_data,
    output logic [$clog2(PAT_MAX+1)-1:0]     pat_len,
    output logic [PAT_MAX-1:0]               pat_dot_mask,
    output logic [PAT_MAX-1:0]               pat_star_mask,
    output logic                             pat_head,
    output logic                             pat_tail,
    output logic                             busy,
    output logic [2:0]                       err
);

    localparam int SLW = $clog2(STR_MAX + 1);
    localparam int PLW = $clog2(PAT_MAX + 1);

    localparam logic [DATA_W-1:0] CH_DOT    = DATA_W'(8'h2E);
    localparam logic [DATA_W-1:0] CH_STAR   = DATA_W'(8'h2A);
    localparam logic [DATA_W-1:0] CH_CARET  = DATA_W'(8'h5E);
    localparam logic [DATA_W-1:0] CH_DOLLAR = DATA_W'(8'h24);

    typedef enum logic [1:0] {
        IDLE,
        LD_STR,
        LD_PAT,
        ISSUE
    } state_t;

    state_t state;

    // Capture FSM: loads string/pattern buffers, classifies pattern chars as they land, and holds the job in ISSUE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            job_valid     <= 1'b0;
            busy          <= 1'b0;
            str_data      <= '0;
            str_len       <= '0;
            pat_data      <= '0;
            pat_len       <= '0;
            pat_dot_mask  <= '0;
            pat_star_mask <= '0;
            pat_head      <= 1'b0;
            pat_tail      <= 1'b0;
            err           <= 3'b000;
        end else if (state == ISSUE) begin
            // Job bus is frozen here; any incoming char is lost.
            if (isstring || ispattern) begin
                err[2] <= 1'b1;
            end
            if (job_ready) begin
                state     <= IDLE;
                job_valid <= 1'b0;
                busy      <= 1'b0;
            end
        end else if (isstring) begin
            // String wins over a simultaneous pattern char; a string during pattern load abandons the pattern.
            if (ispattern || state == LD_PAT) begin
                err[1] <= 1'b1;
            end
            if (state == LD_STR) begin
                if (str_len == SLW'(STR_MAX)) begin
                    err[0] <= 1'b1;
                end else begin
                    for (int i = 0; i < STR_MAX; i++) begin
                        if (str_len == SLW'(i)) begin
                            str_data[i*DATA_W +: DATA_W] <= chardata;
                        end
                    end
                    str_len <= str_len + SLW'(1);
                end
            end else begin
                str_data <= {{((STR_MAX-1)*DATA_W){1'b0}}, chardata};
                str_len  <= SLW'(1);
            end
            state <= LD_STR;
        end else if (ispattern) begin
            if (state == LD_PAT) begin
                if (pat_len == PLW'(PAT_MAX)) begin
                    err[0] <= 1'b1;
                end else begin
                    for (int i = 0; i < PAT_MAX; i++) begin
                        if (pat_len == PLW'(i)) begin
                            pat_data[i*DATA_W +: DATA_W] <= chardata;
                            pat_dot_mask[i]              <= (chardata == CH_DOT);
                            pat_star_mask[i]             <= (chardata == CH_STAR);
                        end
                    end
                    pat_len  <= pat_len + PLW'(1);
                    pat_tail <= (chardata == CH_DOLLAR);
                end
            end else begin
                pat_data      <= {{((PAT_MAX-1)*DATA_W){1'b0}}, chardata};
                pat_len       <= PLW'(1);
                pat_dot_mask  <= {{(PAT_MAX-1){1'b0}}, (chardata == CH_DOT)};
                pat_star_mask <= {{(PAT_MAX-1){1'b0}}, (chardata == CH_STAR)};
                pat_head      <= (chardata == CH_CARET);
                pat_tail      <= (chardata == CH_DOLLAR);
            end
            state <= LD_PAT;
        end else begin
            // An idle cycle closes a pattern into a job; after a string it just returns to IDLE with the string kept.
            if (state == LD_PAT) begin
                state     <= ISSUE;
                job_valid <= 1'b1;
                busy      <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_input_framer.sv
// Bench for input_framer: directed scenarios followed by randomized bursts and free-running random cycles.
// Outputs are checked 1 time unit after every rising edge against a queue-based reference model.
// The model tracks the string and pattern as byte queues and derives masks/flags from their contents.
module tb_input_framer;

    logic         clk;
    logic         reset;
    logic [7:0]   chardata;
    logic         isstring;
    logic         ispattern;
    logic         job_valid;
    logic         job_ready;
    logic [255:0] str_data;
    logic [5:0]   str_len;
    logic [63:0]  pat_data;
    logic [3:0]   pat_len;
    logic [7:0]   pat_dot_mask;
    logic [7:0]   pat_star_mask;
    logic         pat_head;
    logic         pat_tail;
    logic         busy;
    logic [2:0]   err;

    input_framer dut (
        .clk           (clk),
        .reset         (reset),
        .chardata      (chardata),
        .isstring      (isstring),
        .ispattern     (ispattern),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .str_data      (str_data),
        .str_len       (str_len),
        .pat_data      (pat_data),
        .pat_len       (pat_len),
        .pat_dot_mask  (pat_dot_mask),
        .pat_star_mask (pat_star_mask),
        .pat_head      (pat_head),
        .pat_tail      (pat_tail),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] sq[$];
    logic [7:0] pq[$];
    bit         in_str;
    bit         in_pat;
    bit         pend;
    logic [2:0] merr;

    int vectors;
    int miscompares;
    int obs_jobs;
    int exp_jobs;

    logic [7:0] cset [8];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic s, input logic p, input logic [7:0] c,
                              input logic rdy, input logic rst);
        if (!rst) begin
            sq.delete();
            pq.delete();
            in_str = 0;
            in_pat = 0;
            pend   = 0;
            merr   = 3'b000;
        end else if (pend) begin
            if (s || p) merr[2] = 1'b1;
            if (rdy) begin
                pend = 0;
                exp_jobs++;
            end
        end else if (s) begin
            if (p || in_pat) merr[1] = 1'b1;
            if (!in_str) sq.delete();
            if (sq.size() < 32) sq.push_back(c);
            else merr[0] = 1'b1;
            in_str = 1;
            in_pat = 0;
        end else if (p) begin
            if (!in_pat) pq.delete();
            if (pq.size() < 8) pq.push_back(c);
            else merr[0] = 1'b1;
            in_pat = 1;
            in_str = 0;
        end else begin
            if (in_pat) pend = 1;
            in_str = 0;
            in_pat = 0;
        end
    endtask

    task automatic check_all();
        logic [255:0] es;
        logic [63:0]  ep;
        logic [7:0]   ed;
        logic [7:0]   est;
        logic         eh;
        logic         et;
        es  = '0;
        ep  = '0;
        ed  = '0;
        est = '0;
        eh  = 1'b0;
        et  = 1'b0;
        foreach (sq[i]) es[i*8 +: 8] = sq[i];
        foreach (pq[i]) begin
            ep[i*8 +: 8] = pq[i];
            ed[i]        = (pq[i] == 8'h2E);
            est[i]       = (pq[i] == 8'h2A);
        end
        if (pq.size() > 0) begin
            eh = (pq[0] == 8'h5E);
            et = (pq[pq.size()-1] == 8'h24);
        end
        chk("job_valid", 256'(job_valid),     256'(pend));
        chk("busy",      256'(busy),          256'(pend));
        chk("str_data",  str_data,            es);
        chk("str_len",   256'(str_len),       256'(sq.size()));
        chk("pat_data",  256'(pat_data),      256'(ep));
        chk("pat_len",   256'(pat_len),       256'(pq.size()));
        chk("dot_mask",  256'(pat_dot_mask),  256'(ed));
        chk("star_mask", 256'(pat_star_mask), 256'(est));
        chk("pat_head",  256'(pat_head),      256'(eh));
        chk("pat_tail",  256'(pat_tail),      256'(et));
        chk("err",       256'(err),           256'(merr));
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model, check all outputs.
    task automatic cycle(input logic s, input logic p, input logic [7:0] c,
                         input logic rdy, input logic rst);
        isstring  = s;
        ispattern = p;
        chardata  = c;
        job_ready = rdy;
        reset     = rst;
        if (job_valid === 1'b1 && rdy && rst) obs_jobs++;
        @(posedge clk);
        model_step(s, p, c, rdy, rst);
        #1;
        check_all();
    endtask

    task automatic send_str(input string t, input logic rdy);
        for (int i = 0; i < t.len(); i++) cycle(1'b1, 1'b0, t[i], rdy, 1'b1);
    endtask

    task automatic send_pat(input string t, input logic rdy);
        for (int i = 0; i < t.len(); i++) cycle(1'b0, 1'b1, t[i], rdy, 1'b1);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 8'h00, rdy, 1'b1);
    endtask

    initial begin
        int n;
        int slen;
        int plen;
        int k;
        string lng;

        clk         = 1'b0;
        reset       = 1'b0;
        isstring    = 1'b0;
        ispattern   = 1'b0;
        chardata    = 8'h00;
        job_ready   = 1'b0;
        vectors     = 0;
        miscompares = 0;
        obs_jobs    = 0;
        exp_jobs    = 0;
        cset        = '{8'h41, 8'h42, 8'h2E, 8'h2A, 8'h5E, 8'h24, 8'h43, 8'h7A};

        // Reset state
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_err", 256'(err), 256'(3'b000));
        chk("rst_jv",  256'(job_valid), 256'(0));

        // Basic job
        send_str("ABC", 1'b1);
        idle(1'b1);
        send_pat("B", 1'b1);
        idle(1'b1);
        chk("t1_jv",   256'(job_valid), 256'(1));
        chk("t1_slen", 256'(str_len), 256'(3));
        chk("t1_str",  256'(str_data[23:0]), 256'(24'h434241));
        chk("t1_pat",  256'(pat_data[7:0]), 256'(8'h42));
        chk("t1_plen", 256'(pat_len), 256'(1));
        idle(1'b1);
        chk("t1_jv_one", 256'(job_valid), 256'(0));

        // Metachar classification
        send_pat("^A.*$", 1'b1);
        idle(1'b1);
        chk("t2_plen", 256'(pat_len), 256'(5));
        chk("t2_head", 256'(pat_head), 256'(1));
        chk("t2_tail", 256'(pat_tail), 256'(1));
        chk("t2_dot",  256'(pat_dot_mask), 256'(8'b00000100));
        chk("t2_star", 256'(pat_star_mask), 256'(8'b00001000));
        idle(1'b1);

        // String retained across patterns
        send_str("XY", 1'b1);
        idle(1'b1);
        send_pat("X", 1'b1);
        idle(1'b1);
        chk("t3_len_a", 256'(str_len), 256'(2));
        chk("t3_str_a", 256'(str_data[15:0]), 256'(16'h5958));
        idle(1'b1);
        send_pat("Y", 1'b1);
        idle(1'b1);
        chk("t3_len_b", 256'(str_len), 256'(2));
        chk("t3_str_b", 256'(str_data[15:0]), 256'(16'h5958));
        idle(1'b1);

        // Overflow saturation
        lng = "abcdefghijklmnopqrstuvwxyz0123456";
        send_str(lng, 1'b1);
        send_pat("123456789", 1'b1);
        idle(1'b1);
        chk("t4_slen", 256'(str_len), 256'(32));
        chk("t4_last", 256'(str_data[255:248]), 256'(8'h35));
        chk("t4_plen", 256'(pat_len), 256'(8));
        chk("t4_err0", 256'(err[0]), 256'(1));
        idle(1'b1);

        // Backpressure with dropped char
        send_pat("Q", 1'b0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) cycle(1'b0, 1'b1, 8'h51, 1'b0, 1'b1);
            else idle(1'b0);
        end
        chk("t5_jv",   256'(job_valid), 256'(1));
        chk("t5_busy", 256'(busy), 256'(1));
        chk("t5_pat",  256'(pat_data[7:0]), 256'(8'h51));
        chk("t5_err2", 256'(err[2]), 256'(1));
        idle(1'b1);
        chk("t5_done", 256'(job_valid), 256'(0));

        // Reset mid-pattern, then overlap
        send_pat("QR", 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_len", 256'(pat_len), 256'(0));
        chk("t6_err", 256'(err), 256'(0));
        cycle(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
        chk("t6_err1", 256'(err), 256'(3'b010));
        chk("t6_slen", 256'(str_len), 256'(1));
        chk("t6_char", 256'(str_data[7:0]), 256'(8'h5A));
        idle(1'b1);
        chk("t6_nojob", 256'(job_valid), 256'(0));

        // Random bursts with random backpressure
        for (int j = 0; j < 30; j++) begin
            slen = $urandom_range(0, 34);
            for (int i = 0; i < slen; i++) cycle(1'b1, 1'b0, cset[$urandom_range(0, 7)], 1'b0, 1'b1);
            if (slen > 0 && $urandom_range(0, 1) == 1) idle(1'b0);
            plen = $urandom_range(1, 9);
            for (int i = 0; i < plen; i++) cycle(1'b0, 1'b1, cset[$urandom_range(0, 7)], 1'b0, 1'b1);
            idle(1'(($urandom_range(0, 1))));
            n = 0;
            while (job_valid === 1'b1 && n < 40) begin
                k = $urandom_range(0, 9);
                cycle(1'b0, (k == 0), cset[$urandom_range(0, 7)], 1'(($urandom_range(0, 1))), 1'b1);
                n++;
            end
            chk("drain", 256'(job_valid), 256'(0));
        end

        // Free-running random cycles including overlaps and resets
        for (int j = 0; j < 1500; j++) begin
            k = $urandom_range(0, 9);
            cycle((k <= 3) || (k == 7), (k >= 4) && (k <= 7), cset[$urandom_range(0, 7)],
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) >= 2));
        end

        chk("jobs", 256'(obs_jobs), 256'(exp_jobs));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_framer.md
# input_framer

Front-end capture stage for the string-matching engine. Samples the `chardata`/`isstring`/`ispattern` input stream and buffers one string (up to 32 chars) and one pattern (up to 8 chars). It pre-classifies the pattern's special characters and hands a complete job to the downstream matcher datapath over a valid/ready handshake. The string is retained across successive patterns until a new string burst arrives.

## Interface
- `STR_MAX`, default 32: string buffer depth, in characters.
- `PAT_MAX`, default 8: pattern buffer depth, in characters.
- `DATA_W`, default 8: character width.

Clock/reset (already decided): one clock; reset is synchronous and active-low.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `chardata` in 8: input character, ASCII.
- `isstring` in 1: `chardata` is a string character this cycle.
- `ispattern` in 1: `chardata` is a pattern character this cycle.
- `job_valid` out 1: a job is available on the job bus.
- `job_ready` in 1: the matcher accepts the job.
- `str_data` out 256: string; char i is at [8i+7:8i]; unused slots are 0.
- `str_len` out 6: string length, 0..32.
- `pat_data` out 64: pattern; char i is at [8i+7:8i]; unused slots are 0.
- `pat_len` out 4: pattern length, 0..8.
- `pat_dot_mask` out 8: bit i is set when pattern char i is `.` (0x2E).
- `pat_star_mask` out 8: bit i is set when pattern char i is `*` (0x2A).
- `pat_head` out 1: pattern char 0 is `^` (0x5E).
- `pat_tail` out 1: pattern char `pat_len-1` is `$` (0x24).
- `busy` out 1: state is ISSUE; input is not accepted.
- `err` out 3: sticky error flags. [0] overflow, [1] protocol, [2] drop. Cleared only by reset.

## Operation
- FSM states: IDLE, LD_STR, LD_PAT, ISSUE. Encoding is free.
- IDLE:
  - `isstring`: clear the string buffer and mask-free fields, store the char at index 0, set `str_len`=1, go to LD_STR.
  - `ispattern`: clear the pattern buffer, masks, `pat_head` and `pat_tail`; store the char at index 0 and set `pat_len`=1; go to LD_PAT.
- LD_STR:
  - `isstring`: append at index `str_len`. If `str_len`==STR_MAX, discard the char and set `err[0]`.
  - `ispattern`: start a pattern exactly as from IDLE.
  - Neither input high: go to IDLE; the string is retained.
- LD_PAT:
  - `ispattern`: append at index `pat_len`. If `pat_len`==PAT_MAX, discard the char and set `err[0]`.
  - Neither input high: go to ISSUE.
  - `isstring`: set `err[1]`, abandon the pattern, start a new string as from IDLE.
- ISSUE:
  - `job_valid`=1. All job outputs are held constant.
  - On `job_valid & job_ready`: go to IDLE.
  - Any `isstring` or `ispattern` while in ISSUE: discard the char and set `err[2]`.
- `isstring` and `ispattern` both high in any non-ISSUE state: treat as `isstring`, and set `err[1]`.
- Masks, `pat_head` and `pat_tail` are updated on the same edge that stores each pattern char, so they are valid whenever `job_valid`=1.
- A pattern issued with `str_len`=0 is legal and is passed through unchanged.
- Length arithmetic saturates at STR_MAX/PAT_MAX and never wraps.

## Timing
- Reset (`reset`=0 at an edge) forces, on that edge:
  - state to IDLE;
  - `job_valid`, `busy`, all masks, `pat_head`, `pat_tail` to 0;
  - `str_len`, `pat_len` to 0;
  - all buffer slots to 0;
  - `err` to 3'b000.
- Reset asserted mid-load or during ISSUE aborts the job; no job is emitted.
- Chars are accepted on the edge where `isstring`/`ispattern` is sampled high. `str_len`/`pat_len` reflect the char from the next cycle.
- Job latency: the last pattern char is sampled at edge N. The first low-low cycle is sampled at edge N+1, which enters ISSUE. `job_valid`=1 is visible from edge N+1.
- `job_ready` may be held high in advance. The transfer completes on the first edge with both `job_valid` and `job_ready` high. `job_valid`=0 is visible from the next cycle.
- Minimum job-to-job spacing is 3 cycles: 1 pattern char, 1 idle, 1 issue.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
1. String "ABC" (3 cycles), 1 idle, then pattern "B" (1 cycle), 1 idle, `job_ready`=1.
   - Expected: one job with `str_len`=3, `str_data`[23:0]=0x434241, `pat_len`=1, `pat_data`[7:0]=0x42, all flags 0.
   - `job_valid` is high exactly 1 cycle.
2. Pattern "^A.*$", `job_ready`=1.
   - Expected: `pat_len`=5, `pat_head`=1, `pat_tail`=1, `pat_dot_mask`=8'b00000100, `pat_star_mask`=8'b00001000.
3. String "XY" followed by two patterns "X" and "Y", each ending in an idle cycle.
   - Expected: two jobs, both with `str_len`=2 and identical `str_data`.
4. 33 string chars, then 9 pattern chars.
   - Expected: `str_len`=32 holding chars 0..31; `pat_len`=8; `err[0]`=1; no wrap.
5. `job_ready`=0 for 5 cycles while ISSUE, with `ispattern` pulsed in that window.
   - Expected: `job_valid` held, outputs unchanged, `busy`=1, `err[2]`=1.
   - `job_ready`=1 then completes the transfer; IDLE on the next cycle.
6. `reset`=0 for 1 cycle in the middle of loading a pattern.
   - Expected: all outputs 0 on the next cycle; no job issued.
   - A following `isstring`+`ispattern` overlap cycle sets `err[1]` and loads the char as a string.
